// File: rtl/pr_bridge_pkg.sv
// Shared types and defaults for the peripheral bridge (pr_bridge_ctrl).
// Optional macro PR_BRIDGE_IRQ_SYNC_EN is consumed by the top module.
package pr_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [31:0] DEF_DEV0_BASE       = 32'h0000_7F00;
    localparam logic [31:0] DEF_DEV1_BASE       = 32'h0000_7F10;
    localparam int unsigned DEF_DEV_SPAN        = 12;
    localparam int unsigned DEF_TIMEOUT_CYCLES  = 16;
    localparam int unsigned HWINT_W             = 6;

    // Offset form avoids wrap-around when base+span crosses the top of the space.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input int unsigned span);
        return (addr >= base) && ((addr - base) < span);
    endfunction

endpackage

// File: rtl/pr_addr_decode.sv
// Combinational address decode: PrAddr -> {hit1, hit0} for the two timer windows.
module pr_addr_decode
    import pr_bridge_pkg::*;
#(
    parameter logic [31:0] DEV0_BASE = DEF_DEV0_BASE,
    parameter logic [31:0] DEV1_BASE = DEF_DEV1_BASE,
    parameter int unsigned DEV_SPAN  = DEF_DEV_SPAN
) (
    input  logic [31:0] PrAddr,
    output logic [1:0]  hit
);

    always_comb begin
        hit    = '0;
        hit[0] = in_window(PrAddr, DEV0_BASE, DEV_SPAN);
        hit[1] = in_window(PrAddr, DEV1_BASE, DEV_SPAN);
    end

endmodule

// File: rtl/pr_bridge_ctrl.sv
// Memory-stage bridge to timer0/timer1: req/ack sequencing, stall, timeout, HWInt.
// Define PR_BRIDGE_IRQ_SYNC_EN to pass irq through a 2-flop synchronizer.
module pr_bridge_ctrl
    import pr_bridge_pkg::*;
#(
    parameter logic [31:0] DEV0_BASE      = DEF_DEV0_BASE,
    parameter logic [31:0] DEV1_BASE      = DEF_DEV1_BASE,
    parameter int unsigned DEV_SPAN       = DEF_DEV_SPAN,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         PrAddr,
    input  logic [31:0]         PrWD,
    input  logic                PrWE,
    input  logic                PrRE,
    input  logic                IntReq,
    output logic [31:0]         PrRD,
    output logic                stall,
    output logic                bus_err,
    output logic [1:0]          dev_sel,
    output logic                dev_req,
    output logic                dev_we,
    output logic [1:0]          dev_addr,
    output logic [31:0]         dev_wd,
    input  logic [1:0]          dev_ack,
    input  logic [31:0]         dev_rd0,
    input  logic [31:0]         dev_rd1,
    input  logic [1:0]          irq,
    output logic [HWINT_W-1:0]  HWInt
);

    localparam int unsigned        CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       hit;
    logic             go;
    logic             ack_hit;
    logic [31:0]      rd_sel;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      PrRD_q, PrRD_d;
    logic             bus_err_q, bus_err_d;
    logic [1:0]       dev_sel_q, dev_sel_d;
    logic             dev_req_q, dev_req_d;
    logic             dev_we_q, dev_we_d;
    logic [1:0]       dev_addr_q, dev_addr_d;
    logic [31:0]      dev_wd_q, dev_wd_d;

    pr_addr_decode #(
        .DEV0_BASE (DEV0_BASE),
        .DEV1_BASE (DEV1_BASE),
        .DEV_SPAN  (DEV_SPAN)
    ) u_decode (
        .PrAddr (PrAddr),
        .hit    (hit)
    );

    assign go      = (PrWE | PrRE) & (|hit) & ~IntReq;
    // Only the device latched into dev_sel may complete the access.
    assign ack_hit = |(dev_ack & dev_sel_q);
    assign rd_sel  = dev_sel_q[1] ? dev_rd1 : dev_rd0;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        PrRD_d     = PrRD_q;
        bus_err_d  = bus_err_q;
        dev_sel_d  = dev_sel_q;
        dev_req_d  = dev_req_q;
        dev_we_d   = dev_we_q;
        dev_addr_d = dev_addr_q;
        dev_wd_d   = dev_wd_q;
        stall      = 1'b0;

        case (state_q)
            IDLE: begin
                if (go) begin
                    stall      = 1'b1;
                    dev_sel_d  = hit;
                    dev_we_d   = PrWE;
                    dev_addr_d = PrAddr[3:2];
                    dev_wd_d   = PrWD;
                    dev_req_d  = 1'b1;
                    cnt_d      = '0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                // Ack takes priority over a timeout landing in the same cycle.
                if (ack_hit) begin
                    if (!dev_we_q) begin
                        PrRD_d = rd_sel;
                    end
                    dev_req_d = 1'b0;
                    state_d   = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    dev_req_d = 1'b0;
                    PrRD_d    = '0;
                    bus_err_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                bus_err_d = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            PrRD_q     <= '0;
            bus_err_q  <= 1'b0;
            dev_sel_q  <= '0;
            dev_req_q  <= 1'b0;
            dev_we_q   <= 1'b0;
            dev_addr_q <= '0;
            dev_wd_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            PrRD_q     <= PrRD_d;
            bus_err_q  <= bus_err_d;
            dev_sel_q  <= dev_sel_d;
            dev_req_q  <= dev_req_d;
            dev_we_q   <= dev_we_d;
            dev_addr_q <= dev_addr_d;
            dev_wd_q   <= dev_wd_d;
        end
    end

    assign PrRD     = PrRD_q;
    assign bus_err  = bus_err_q;
    assign dev_sel  = dev_sel_q;
    assign dev_req  = dev_req_q;
    assign dev_we   = dev_we_q;
    assign dev_addr = dev_addr_q;
    assign dev_wd   = dev_wd_q;

`ifdef PR_BRIDGE_IRQ_SYNC_EN
    logic [1:0] irq_s1_q, irq_s1_d;
    logic [1:0] irq_s2_q, irq_s2_d;

    always_comb begin
        irq_s1_d = irq;
        irq_s2_d = irq_s1_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_s1_q <= '0;
            irq_s2_q <= '0;
        end else begin
            irq_s1_q <= irq_s1_d;
            irq_s2_q <= irq_s2_d;
        end
    end

    assign HWInt = {{(HWINT_W-2){1'b0}}, irq_s2_q};
`else
    assign HWInt = {{(HWINT_W-2){1'b0}}, irq};
`endif

endmodule
